// File: rtl/kf_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kf_step_ctrl_pkg
// Description : Shared definitions for the Kalman-filter step sequencer:
//               state encoding, default phase timeout and the names of the
//               start/done handshake bundle used by the datapath wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package kf_step_ctrl_pkg;

    // Sequencer states, explicitly encoded on three bits.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRED_WAIT = 3'd1,
        ST_GAIN_WAIT = 3'd2,
        ST_UPD_WAIT  = 3'd3,
        ST_FINISH    = 3'd4
    } kf_state_t;

    // Default number of cycles a phase may wait for its done pulses.
    localparam int unsigned c_timeout_default = 64;

    // One bit per arithmetic sub-block, shared by start and done bundles.
    typedef struct packed {
        logic ps;   // prior state
        logic pc;   // prior covariance
        logic kg;   // Kalman gain
        logic us;   // posterior state update
        logic uc;   // posterior covariance update
    } kf_hs_t;

endpackage
`default_nettype wire

// File: rtl/kf_step_ctrl_pair.sv
`default_nettype none
// ============================================================================
// Module      : kf_pair_join
// Description : Joins two independent done pulses. Each pulse is latched in
//               its own flag while the phase is active; 'both' is raised as
//               soon as both have been seen, including the cycle the second
//               one arrives. Flags are wiped on phase entry.
// Revision    : 1.0 - initial release
// ============================================================================
module kf_pair_join (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a_done,
    input  logic b_done,
    output logic both
);

    logic r_a_seen;
    logic r_b_seen;

    // Latch each done pulse while the phase is active; clear on phase entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
        end else if (clr) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
        end else if (en) begin
            r_a_seen <= r_a_seen | a_done;
            r_b_seen <= r_b_seen | b_done;
        end
    end

    // A pulse arriving this cycle counts as already seen.
    assign both = en & (r_a_seen | a_done) & (r_b_seen | b_done);

endmodule
`default_nettype wire

// File: rtl/kf_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kf_step_ctrl
// Description : Sequencer for one Kalman-filter iteration. Launches the
//               predict pair, optionally the gain and the update pair, and
//               reports completion, skipped update or phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module kf_step_ctrl
    import kf_step_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_timeout_default,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             meas_valid,
    input  logic             abort,
    input  logic             ps_done,
    input  logic             pc_done,
    input  logic             kg_done,
    input  logic             us_done,
    input  logic             uc_done,
    output logic             ps_start,
    output logic             pc_start,
    output logic             kg_start,
    output logic             us_start,
    output logic             uc_start,
    output logic             busy,
    output logic             done,
    output logic             skip_upd,
    output logic             err_timeout,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    kf_state_t       r_state;
    kf_state_t       w_state_nxt;
    logic            r_meas;
    logic [TO_W-1:0] r_to_cnt;

    kf_hs_t          w_start_nxt;
    logic            w_done_nxt;
    logic            w_accept;
    logic            w_timeout;
    logic            w_wait;
    logic            w_to_hit;
    logic            w_pred_both;
    logic            w_upd_both;
    logic            w_pred_clr;
    logic            w_upd_clr;

    assign w_wait     = (r_state == ST_PRED_WAIT) || (r_state == ST_GAIN_WAIT) ||
                        (r_state == ST_UPD_WAIT);
    assign w_to_hit   = w_wait && (r_to_cnt == c_to_last);
    assign w_pred_clr = (w_state_nxt == ST_PRED_WAIT) && (r_state != ST_PRED_WAIT);
    assign w_upd_clr  = (w_state_nxt == ST_UPD_WAIT)  && (r_state != ST_UPD_WAIT);

    kf_pair_join u_pred_join (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_pred_clr),
        .en     (r_state == ST_PRED_WAIT),
        .a_done (ps_done),
        .b_done (pc_done),
        .both   (w_pred_both)
    );

    kf_pair_join u_upd_join (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_upd_clr),
        .en     (r_state == ST_UPD_WAIT),
        .a_done (us_done),
        .b_done (uc_done),
        .both   (w_upd_both)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the registered outputs; abort beats
    // completion, and completion beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = '0;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept       = 1'b1;
                    w_start_nxt.ps = 1'b1;
                    w_start_nxt.pc = 1'b1;
                    w_state_nxt    = ST_PRED_WAIT;
                end
            end
            ST_PRED_WAIT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pred_both) begin
                    if (r_meas) begin
                        w_start_nxt.kg = 1'b1;
                        w_state_nxt    = ST_GAIN_WAIT;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAIN_WAIT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (kg_done) begin
                    w_start_nxt.us = 1'b1;
                    w_start_nxt.uc = 1'b1;
                    w_state_nxt    = ST_UPD_WAIT;
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_UPD_WAIT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_upd_both) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_FINISH;
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase timeout counter: restarts on every state change, runs while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_to_cnt <= '0;
        end else if (w_wait) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Registered outputs and per-step status captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_start    <= 1'b0;
            pc_start    <= 1'b0;
            kg_start    <= 1'b0;
            us_start    <= 1'b0;
            uc_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            skip_upd    <= 1'b0;
            err_timeout <= 1'b0;
            step_cnt    <= '0;
            r_meas      <= 1'b0;
        end else begin
            ps_start <= w_start_nxt.ps;
            pc_start <= w_start_nxt.pc;
            kg_start <= w_start_nxt.kg;
            us_start <= w_start_nxt.us;
            uc_start <= w_start_nxt.uc;
            busy     <= (w_state_nxt != ST_IDLE);
            done     <= w_done_nxt;
            if (w_done_nxt) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_meas      <= meas_valid;
                skip_upd    <= ~meas_valid;
                err_timeout <= 1'b0;
            end else if (w_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kf_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kf_step_ctrl
// Description : Self-checking bench for kf_step_ctrl. Stub sub-blocks answer
//               each start pulse after a chosen latency; expected event
//               cycles come from a phase-level timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kf_step_ctrl;

    localparam int c_to   = 16;
    localparam int c_cw   = 2;
    localparam int c_none = -1;

    logic clk = 1'b0;
    logic rst_n;
    logic start, meas_valid, abort;
    logic ps_done, pc_done, kg_done, us_done, uc_done;
    logic ps_start, pc_start, kg_start, us_start, uc_start;
    logic busy, done, skip_upd, err_timeout;
    logic [c_cw-1:0] step_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int model_cnt = 0;
    int last_kg, last_done, last_nkg, last_cnt;

    kf_step_ctrl #(
        .TIMEOUT (c_to),
        .TO_W    (8),
        .CNT_W   (c_cw)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .meas_valid  (meas_valid),
        .abort       (abort),
        .ps_done     (ps_done),
        .pc_done     (pc_done),
        .kg_done     (kg_done),
        .us_done     (us_done),
        .uc_done     (uc_done),
        .ps_start    (ps_start),
        .pc_start    (pc_start),
        .kg_start    (kg_start),
        .us_start    (us_start),
        .uc_start    (uc_start),
        .busy        (busy),
        .done        (done),
        .skip_upd    (skip_upd),
        .err_timeout (err_timeout),
        .step_cnt    (step_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the bench itself wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, got no summary expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int outs_vec();
        return int'({ps_start, pc_start, kg_start, us_start, uc_start,
                     busy, done, skip_upd, err_timeout, step_cnt});
    endfunction

    task automatic clear_inputs();
        start = 0; meas_valid = 0; abort = 0;
        ps_done = 0; pc_done = 0; kg_done = 0; us_done = 0; uc_done = 0;
    endtask

    // One filter step: start driven in relative cycle 0, outputs sampled
    // mid-cycle, stubs answer L cycles after the cycle their start was seen.
    task automatic run_step(input int lps, input int lpc, input int lkg,
                            input int lus, input int luc, input bit meas,
                            input bit spam, input bit stray,
                            input int abort_at, input int reset_at);
        int e, exp_kg, exp_us, exp_done, exp_to, exp_end;
        int o_ps, o_pc, o_kg, o_us, o_uc, o_done, o_to, o_end;
        int c_ps, c_pc, c_kg, c_us, c_uc, c_done;
        int s_ps, s_pc, s_kg, s_us, s_uc;
        int err1, skip1, err_e, skip_e, cnt_e;
        bit did_reset;

        // Phase-level timing model.
        exp_kg = c_none; exp_us = c_none; exp_done = c_none; exp_to = c_none;
        e = 1;
        if (mx(lps, lpc) > c_to - 1) exp_to = e + c_to;
        else begin
            e = e + mx(lps, lpc) + 1;
            if (!meas) exp_done = e;
            else begin
                exp_kg = e;
                if (lkg > c_to - 1) exp_to = e + c_to;
                else begin
                    e = e + lkg + 1;
                    exp_us = e;
                    if (mx(lus, luc) > c_to - 1) exp_to = e + c_to;
                    else exp_done = e + mx(lus, luc) + 1;
                end
            end
        end
        exp_end = (exp_to != c_none) ? exp_to : exp_done + 1;
        if (abort_at > 0 && abort_at < exp_end) begin
            if (exp_kg   > abort_at) exp_kg   = c_none;
            if (exp_us   > abort_at) exp_us   = c_none;
            if (exp_done > abort_at) exp_done = c_none;
            if (exp_to   > abort_at) exp_to   = c_none;
            exp_end = abort_at + 1;
        end

        o_ps = c_none; o_pc = c_none; o_kg = c_none; o_us = c_none; o_uc = c_none;
        o_done = c_none; o_to = c_none; o_end = c_none;
        c_ps = 0; c_pc = 0; c_kg = 0; c_us = 0; c_uc = 0; c_done = 0;
        s_ps = c_none; s_pc = c_none; s_kg = c_none; s_us = c_none; s_uc = c_none;
        err1 = c_none; skip1 = c_none; err_e = c_none; skip_e = c_none; cnt_e = c_none;
        did_reset = 0;

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if (ps_start) begin c_ps++; if (o_ps < 0) o_ps = n; s_ps = n + lps; end
                if (pc_start) begin c_pc++; if (o_pc < 0) o_pc = n; s_pc = n + lpc; end
                if (kg_start) begin c_kg++; if (o_kg < 0) o_kg = n; s_kg = n + lkg; end
                if (us_start) begin c_us++; if (o_us < 0) o_us = n; s_us = n + lus; end
                if (uc_start) begin c_uc++; if (o_uc < 0) o_uc = n; s_uc = n + luc; end
                if (done) begin c_done++; if (o_done < 0) o_done = n; end
                if (err_timeout && o_to < 0) o_to = n;
                if (n == 1) begin err1 = int'(err_timeout); skip1 = int'(skip_upd); end
                if (n == reset_at) begin
                    check("pre_reset_busy", int'(busy), 1);
                    check("pre_reset_us_start", o_us, exp_us);
                    #1 rst_n = 0;
                    #1 check("async_reset_outputs", outs_vec(), 0);
                    clear_inputs();
                    repeat (2) @(negedge clk);
                    check("held_reset_outputs", outs_vec(), 0);
                    rst_n = 1;
                    model_cnt = 0;
                    did_reset = 1;
                    break;
                end
                if (n >= 2 && !busy) begin
                    o_end = n; err_e = int'(err_timeout);
                    skip_e = int'(skip_upd); cnt_e = int'(step_cnt);
                    break;
                end
            end
            start   = (n == 0) || (spam && busy);
            meas_valid = meas;
            abort   = (n == abort_at);
            ps_done = (n == s_ps);
            pc_done = (n == s_pc);
            kg_done = (n == s_kg) || (stray && n == 2);
            us_done = (n == s_us);
            uc_done = (n == s_uc);
        end
        clear_inputs();
        if (did_reset) return;

        if (exp_done != c_none) model_cnt = (model_cnt + 1) % (1 << c_cw);
        check("step_end_cycle", o_end, exp_end);
        check("ps_start_cycle", o_ps, 1);
        check("pc_start_cycle", o_pc, 1);
        check("ps_start_count", c_ps + c_pc, 2);
        check("kg_start_cycle", o_kg, exp_kg);
        check("kg_start_count", c_kg, (exp_kg != c_none) ? 1 : 0);
        check("us_start_cycle", o_us, exp_us);
        check("uc_start_cycle", o_uc, exp_us);
        check("upd_start_count", c_us + c_uc, (exp_us != c_none) ? 2 : 0);
        check("done_cycle", o_done, exp_done);
        check("done_count", c_done, (exp_done != c_none) ? 1 : 0);
        check("timeout_cycle", o_to, exp_to);
        check("err_cleared_on_start", err1, 0);
        check("skip_upd_start", skip1, meas ? 0 : 1);
        check("err_timeout_end", err_e, (exp_to != c_none) ? 1 : 0);
        check("skip_upd_end", skip_e, meas ? 0 : 1);
        check("step_cnt", cnt_e, model_cnt);
        last_kg = o_kg; last_done = o_done; last_nkg = c_kg; last_cnt = cnt_e;
    endtask

    initial begin
        int lat[5];
        bit m, sp;
        int ab;
        rst_n = 0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), 0);
        rst_n = 1;
        @(negedge clk);
        check("idle_after_reset", outs_vec(), 0);

        // Full step with measurement.
        run_step(8, 5, 3, 6, 4, 1, 0, 0, c_none, c_none);
        check("full_kg_cycle", last_kg, 10);
        check("full_done_cycle", last_done, 21);
        check("full_step_cnt", last_cnt, 1);

        // No measurement: prediction only.
        run_step(8, 5, 3, 6, 4, 0, 0, 0, c_none, c_none);
        check("nomeas_done_cycle", last_done, 10);

        // Simultaneous predict dones plus a stray gain done.
        run_step(4, 4, 3, 6, 4, 1, 0, 1, c_none, c_none);
        check("simul_kg_cycle", last_kg, 6);
        check("simul_kg_count", last_nkg, 1);

        // Gain never answers, then a normal step clears the error.
        run_step(3, 3, 255, 2, 2, 1, 0, 0, c_none, c_none);
        run_step(3, 3, 2, 2, 2, 1, 0, 0, c_none, c_none);

        // Completion on the last allowed cycle vs one cycle late.
        run_step(15, 2, 15, 15, 1, 1, 0, 0, c_none, c_none);
        run_step(16, 2, 3, 3, 3, 1, 0, 0, c_none, c_none);
        run_step(2, 2, 2, 3, 16, 1, 0, 0, c_none, c_none);

        // Start held high throughout a step; abort during gain wait.
        run_step(6, 4, 5, 3, 7, 1, 1, 0, c_none, c_none);
        run_step(4, 4, 10, 3, 3, 1, 0, 0, 9, c_none);
        // Abort together with start in IDLE is ignored.
        run_step(3, 2, 2, 2, 2, 1, 0, 0, 0, c_none);

        // Reset in UPD_WAIT, then five steps wrap the 2-bit counter to 1.
        run_step(8, 5, 3, 6, 4, 1, 0, 0, c_none, 17);
        run_step(8, 5, 3, 6, 4, 1, 0, 0, c_none, c_none);
        check("fresh_step_cnt", last_cnt, 1);
        for (int i = 0; i < 4; i++) run_step(2, 3, 1, 2, 1, 1, 0, 0, c_none, c_none);
        check("wrap_step_cnt", last_cnt, 1);

        // Randomized steps.
        for (int i = 0; i < 30; i++) begin
            for (int j = 0; j < 5; j++)
                lat[j] = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20)
                                                     : $urandom_range(1, 15);
            m  = 1'($urandom_range(0, 1));
            sp = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : c_none;
            run_step(lat[0], lat[1], lat[2], lat[3], lat[4], m, sp, 0, ab, c_none);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
